// File: rtl/ctrl_decode_rv32m.sv
// ctrl_decode_rv32m
//   RV32I/RV32M decoder for the instruction in ID, registered into the ID/EX
//   control register. A 6-bit occupancy counter holds that register while a
//   multi-cycle MUL/DIV is in EX and reports it on MulDivBusy.
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   InstrD, ValidD  : instruction in ID and its valid qualifier
//   StallE, FlushE  : hold / clear of the EX register from the hazard unit
//   JalD, JalrD     : combinational early-redirect flags
//   *E outputs      : registered control fields for EX
//   MulDivBusy      : EX is held by an in-flight multiply/divide
module ctrl_decode_rv32m #(
    parameter int M_EXT       = 1,
    parameter int MUL_LATENCY = 2,
    parameter int DIV_LATENCY = 33,
    parameter int ALU_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      InstrD,
    input  logic             ValidD,
    input  logic             StallE,
    input  logic             FlushE,
    output logic             JalD,
    output logic             JalrD,
    output logic             ValidE,
    output logic             IllegalE,
    output logic [2:0]       RegWriteE,
    output logic             MemToRegE,
    output logic [3:0]       MemWriteE,
    output logic             LoadNpcE,
    output logic [1:0]       RegReadE,
    output logic [2:0]       BranchTypeE,
    output logic [ALU_W-1:0] AluContrlE,
    output logic             AluSrc1E,
    output logic [1:0]       AluSrc2E,
    output logic [2:0]       ImmTypeE,
    output logic             JalE,
    output logic             JalrE,
    output logic             MulDivBusy
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                           OP_JAL = 7'b1101111, OP_JALR  = 7'b1100111,
                           OP_BR  = 7'b1100011, OP_LD    = 7'b0000011,
                           OP_ST  = 7'b0100011, OP_IMM   = 7'b0010011,
                           OP_OP  = 7'b0110011, OP_FENCE = 7'b0001111;
    localparam logic [4:0] A_SLL = 5'd0, A_SRL = 5'd1, A_SRA = 5'd2, A_ADD = 5'd3,
                           A_SUB = 5'd4, A_XOR = 5'd5, A_OR  = 5'd6, A_AND = 5'd7,
                           A_SLT = 5'd8, A_SLTU = 5'd9, A_LUI = 5'd10, A_MUL = 5'd11;
    localparam logic [2:0] IMM_I = 3'd1, IMM_S = 3'd2, IMM_B = 3'd3, IMM_U = 3'd4, IMM_J = 3'd5;
    localparam logic [5:0] MUL_CNT = 6'(MUL_LATENCY - 1);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LATENCY - 1);

    typedef struct packed {
        logic             valid;
        logic             illegal;
        logic [2:0]       regwrite;
        logic             memtoreg;
        logic [3:0]       memwrite;
        logic             loadnpc;
        logic [1:0]       regread;
        logic [2:0]       branch;
        logic [ALU_W-1:0] alu;
        logic             alusrc1;
        logic [1:0]       alusrc2;
        logic [2:0]       immtype;
        logic             jal;
        logic             jalr;
    } ctrl_t;

    ctrl_t      w_dec, r_ex;
    logic [5:0] r_cnt;
    logic [6:0] w_op, w_f7;
    logic [2:0] w_f3;
    logic [4:0] w_alu, w_base;
    logic       w_ill, w_mop, w_div;
    logic       w_unused_bits;

    assign w_op          = InstrD[6:0];
    assign w_f3          = InstrD[14:12];
    assign w_f7          = InstrD[31:25];
    assign w_unused_bits = ^{InstrD[24:15], InstrD[11:7]};

    // funct3 -> ALU op shared by OP-IMM and OP with funct7 = 0
    always_comb begin
        case (w_f3)
            3'b000:  w_base = A_ADD;
            3'b001:  w_base = A_SLL;
            3'b010:  w_base = A_SLT;
            3'b011:  w_base = A_SLTU;
            3'b100:  w_base = A_XOR;
            3'b101:  w_base = A_SRL;
            3'b110:  w_base = A_OR;
            default: w_base = A_AND;
        endcase
    end

    always_comb begin
        w_dec = '0;
        w_alu = A_ADD;
        w_ill = 1'b0;
        w_mop = 1'b0;
        w_div = 1'b0;
        case (w_op)
            OP_LUI: begin
                w_dec.regwrite = 3'd3; w_alu = A_LUI;
                w_dec.alusrc2 = 2'b10; w_dec.immtype = IMM_U;
            end
            OP_AUIPC: begin
                w_dec.regwrite = 3'd3; w_dec.alusrc1 = 1'b1;
                w_dec.alusrc2 = 2'b10; w_dec.immtype = IMM_U;
            end
            OP_JAL: begin
                w_dec.regwrite = 3'd3; w_dec.loadnpc = 1'b1;
                w_dec.jal = 1'b1; w_dec.immtype = IMM_J;
            end
            OP_JALR: begin
                w_ill = (w_f3 != 3'b000);
                w_dec.regwrite = 3'd3; w_dec.loadnpc = 1'b1; w_dec.jalr = 1'b1;
                w_dec.immtype = IMM_I; w_dec.regread = 2'b10; w_dec.alusrc2 = 2'b10;
            end
            OP_BR: begin
                w_dec.immtype = IMM_B; w_dec.regread = 2'b11;
                case (w_f3)
                    3'b000:  w_dec.branch = 3'd1;
                    3'b001:  w_dec.branch = 3'd2;
                    3'b100:  w_dec.branch = 3'd3;
                    3'b110:  w_dec.branch = 3'd4;
                    3'b101:  w_dec.branch = 3'd5;
                    3'b111:  w_dec.branch = 3'd6;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_LD: begin
                w_dec.memtoreg = 1'b1; w_dec.immtype = IMM_I;
                w_dec.regread = 2'b10; w_dec.alusrc2 = 2'b10;
                case (w_f3)
                    3'b000:  w_dec.regwrite = 3'd1;
                    3'b001:  w_dec.regwrite = 3'd2;
                    3'b010:  w_dec.regwrite = 3'd3;
                    3'b100:  w_dec.regwrite = 3'd4;
                    3'b101:  w_dec.regwrite = 3'd5;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_ST: begin
                w_dec.immtype = IMM_S; w_dec.regread = 2'b11; w_dec.alusrc2 = 2'b10;
                case (w_f3)
                    3'b000:  w_dec.memwrite = 4'b0001;
                    3'b001:  w_dec.memwrite = 4'b0011;
                    3'b010:  w_dec.memwrite = 4'b1111;
                    default: w_ill = 1'b1;
                endcase
            end
            OP_IMM: begin
                w_dec.regwrite = 3'd3; w_dec.immtype = IMM_I; w_dec.regread = 2'b10;
                w_alu = w_base;
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    // shifts take the shamt field, funct7 selects SRL/SRA
                    w_dec.alusrc2 = 2'b01;
                    if (w_f3 == 3'b101 && w_f7 == 7'b0100000) w_alu = A_SRA;
                    else if (w_f7 != 7'b0000000)              w_ill = 1'b1;
                end else begin
                    w_dec.alusrc2 = 2'b10;
                end
            end
            OP_OP: begin
                w_dec.regwrite = 3'd3; w_dec.regread = 2'b11;
                if (w_f7 == 7'b0000000)                        w_alu = w_base;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) w_alu = A_SUB;
                else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) w_alu = A_SRA;
                else if (w_f7 == 7'b0000001 && M_EXT != 0) begin
                    // MUL..REMU are consecutive codes indexed by funct3
                    w_alu = A_MUL + {2'b00, w_f3};
                    w_mop = 1'b1;
                    w_div = w_f3[2];
                end else begin
                    w_ill = 1'b1;
                end
            end
            OP_FENCE: ;
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_dec = '0;
            w_alu = A_ADD;
            w_mop = 1'b0;
        end
        w_dec.illegal = w_ill;
        w_dec.valid   = 1'b1;
        w_dec.alu     = ALU_W'(w_alu);
        if (!ValidD) begin
            w_dec = '0;
            w_mop = 1'b0;
        end
    end

    // rst > FlushE > busy hold > StallE hold > capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex  <= '0;
            r_cnt <= 6'd0;
        end else if (FlushE) begin
            r_ex  <= '0;
            r_cnt <= 6'd0;
        end else if (r_cnt != 6'd0) begin
            r_cnt <= r_cnt - 6'd1;
        end else if (!StallE) begin
            r_ex  <= w_dec;
            r_cnt <= w_mop ? (w_div ? DIV_CNT : MUL_CNT) : 6'd0;
        end
    end

    assign JalD        = ValidD & (w_op == OP_JAL);
    assign JalrD       = ValidD & (w_op == OP_JALR);
    assign ValidE      = r_ex.valid;
    assign IllegalE    = r_ex.illegal;
    assign RegWriteE   = r_ex.regwrite;
    assign MemToRegE   = r_ex.memtoreg;
    assign MemWriteE   = r_ex.memwrite;
    assign LoadNpcE    = r_ex.loadnpc;
    assign RegReadE    = r_ex.regread;
    assign BranchTypeE = r_ex.branch;
    assign AluContrlE  = r_ex.alu;
    assign AluSrc1E    = r_ex.alusrc1;
    assign AluSrc2E    = r_ex.alusrc2;
    assign ImmTypeE    = r_ex.immtype;
    assign JalE        = r_ex.jal;
    assign JalrE       = r_ex.jalr;
    assign MulDivBusy  = (r_cnt != 6'd0);
endmodule

// File: tb/tb_ctrl_decode_rv32m.sv
module tb_ctrl_decode_rv32m;
  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;

  typedef struct packed {
    logic valid; logic illegal; logic [2:0] rw; logic m2r; logic [3:0] mw;
    logic npc; logic [1:0] rr; logic [2:0] br; logic [4:0] alu; logic s1;
    logic [1:0] s2; logic [2:0] imm; logic jal; logic jalr; logic busy;
  } exp_t;

  logic clk, rst, ValidD, StallE, FlushE;
  logic [31:0] InstrD;

  // _m : M_EXT=1 instance, _i : M_EXT=0 instance
  logic JalD_m, JalrD_m, ValidE_m, IllegalE_m, MemToRegE_m, LoadNpcE_m, AluSrc1E_m, JalE_m, JalrE_m, Busy_m;
  logic [2:0] RegWriteE_m, BranchTypeE_m, ImmTypeE_m;
  logic [3:0] MemWriteE_m;
  logic [1:0] RegReadE_m, AluSrc2E_m;
  logic [4:0] AluContrlE_m;
  logic JalD_i, JalrD_i, ValidE_i, IllegalE_i, MemToRegE_i, LoadNpcE_i, AluSrc1E_i, JalE_i, JalrE_i, Busy_i;
  logic [2:0] RegWriteE_i, BranchTypeE_i, ImmTypeE_i;
  logic [3:0] MemWriteE_i;
  logic [1:0] RegReadE_i, AluSrc2E_i;
  logic [4:0] AluContrlE_i;

  ctrl_decode_rv32m #(.M_EXT(1), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .ALU_W(5)) u_m (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .JalD(JalD_m), .JalrD(JalrD_m), .ValidE(ValidE_m), .IllegalE(IllegalE_m), .RegWriteE(RegWriteE_m),
    .MemToRegE(MemToRegE_m), .MemWriteE(MemWriteE_m), .LoadNpcE(LoadNpcE_m), .RegReadE(RegReadE_m),
    .BranchTypeE(BranchTypeE_m), .AluContrlE(AluContrlE_m), .AluSrc1E(AluSrc1E_m), .AluSrc2E(AluSrc2E_m),
    .ImmTypeE(ImmTypeE_m), .JalE(JalE_m), .JalrE(JalrE_m), .MulDivBusy(Busy_m));

  ctrl_decode_rv32m #(.M_EXT(0), .MUL_LATENCY(MUL_LAT), .DIV_LATENCY(DIV_LAT), .ALU_W(5)) u_i (
    .clk(clk), .rst(rst), .InstrD(InstrD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE),
    .JalD(JalD_i), .JalrD(JalrD_i), .ValidE(ValidE_i), .IllegalE(IllegalE_i), .RegWriteE(RegWriteE_i),
    .MemToRegE(MemToRegE_i), .MemWriteE(MemWriteE_i), .LoadNpcE(LoadNpcE_i), .RegReadE(RegReadE_i),
    .BranchTypeE(BranchTypeE_i), .AluContrlE(AluContrlE_i), .AluSrc1E(AluSrc1E_i), .AluSrc2E(AluSrc2E_i),
    .ImmTypeE(ImmTypeE_i), .JalE(JalE_i), .JalrE(JalrE_i), .MulDivBusy(Busy_i));

  logic [29:0] act_m, act_i;
  assign act_m = {ValidE_m, IllegalE_m, RegWriteE_m, MemToRegE_m, MemWriteE_m, LoadNpcE_m, RegReadE_m,
                  BranchTypeE_m, AluContrlE_m, AluSrc1E_m, AluSrc2E_m, ImmTypeE_m, JalE_m, JalrE_m, Busy_m};
  assign act_i = {ValidE_i, IllegalE_i, RegWriteE_i, MemToRegE_i, MemWriteE_i, LoadNpcE_i, RegReadE_i,
                  BranchTypeE_i, AluContrlE_i, AluSrc1E_i, AluSrc2E_i, ImmTypeE_i, JalE_i, JalrE_i, Busy_i};

  int total = 0;
  int bad = 0;
  logic [59:0] q[$];
  exp_t cur[2];
  int left[2];

  // spec tables indexed by funct3; -1 marks an illegal encoding
  int BR_T[8] = '{1, 2, -1, -1, 3, 5, 4, 6};
  int LD_T[8] = '{1, 2, 3, -1, 4, 5, -1, -1};
  int ST_T[8] = '{1, 3, 15, -1, -1, -1, -1, -1};
  int AL_T[8] = '{3, 0, 8, 9, 5, 1, 6, 7};
  logic [6:0] OPS[12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h33};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] ins, input logic v, input logic mext, output int lat);
    exp_t e;
    logic ill;
    logic [6:0] op, f7;
    logic [2:0] f3;
    int t;
    e = '0; ill = 1'b0; lat = 0; t = 0;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    if (!v) return e;
    e.valid = 1'b1;
    e.alu = 5'd3;
    case (op)
      7'h37: begin e.rw = 3'd3; e.alu = 5'd10; e.s2 = 2'd2; e.imm = 3'd4; end
      7'h17: begin e.rw = 3'd3; e.s1 = 1'b1; e.s2 = 2'd2; e.imm = 3'd4; end
      7'h6F: begin e.rw = 3'd3; e.npc = 1'b1; e.jal = 1'b1; e.imm = 3'd5; end
      7'h67: begin
        ill = (f3 != 3'd0);
        e.rw = 3'd3; e.npc = 1'b1; e.jalr = 1'b1; e.imm = 3'd1; e.rr = 2'd2; e.s2 = 2'd2;
      end
      7'h63: begin t = BR_T[f3]; ill = (t < 0); e.br = 3'(t); e.imm = 3'd3; e.rr = 2'd3; end
      7'h03: begin t = LD_T[f3]; ill = (t < 0); e.rw = 3'(t); e.m2r = 1'b1; e.imm = 3'd1; e.rr = 2'd2; e.s2 = 2'd2; end
      7'h23: begin t = ST_T[f3]; ill = (t < 0); e.mw = 4'(t); e.imm = 3'd2; e.rr = 2'd3; e.s2 = 2'd2; end
      7'h13: begin
        e.rw = 3'd3; e.imm = 3'd1; e.rr = 2'd2; e.alu = 5'(AL_T[f3]);
        e.s2 = (f3 == 3'd1 || f3 == 3'd5) ? 2'd1 : 2'd2;
        if (f3 == 3'd1 && f7 != 7'd0) ill = 1'b1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) e.alu = 5'd2;
          else if (f7 != 7'd0) ill = 1'b1;
        end
      end
      7'h33: begin
        e.rw = 3'd3; e.rr = 2'd3;
        if (f7 == 7'd0) e.alu = 5'(AL_T[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) e.alu = 5'd4;
        else if (f7 == 7'h20 && f3 == 3'd5) e.alu = 5'd2;
        else if (f7 == 7'h01 && mext) begin
          e.alu = 5'(11 + int'(f3));
          lat = f3[2] ? DIV_LAT : MUL_LAT;
        end else ill = 1'b1;
      end
      7'h0F: ;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e = '0; e.valid = 1'b1; e.illegal = 1'b1; e.alu = 5'd3; lat = 0;
    end
    return e;
  endfunction

  // drive one cycle of inputs, advance the reference, queue what EX must show after the edge
  task automatic step(input logic [31:0] ins, input logic v, input logic st, input logic fl);
    int lat;
    logic jw, jrw;
    @(negedge clk);
    rst = 1'b0;
    InstrD = ins; ValidD = v; StallE = st; FlushE = fl;
    #1;
    jw  = v && (ins[6:0] == 7'h6F);
    jrw = v && (ins[6:0] == 7'h67);
    chk("jal_d", {60'd0, JalD_m, JalrD_m, JalD_i, JalrD_i}, {60'd0, jw, jrw, jw, jrw});
    for (int k = 0; k < 2; k++) begin
      if (fl) begin
        cur[k] = '0; left[k] = 0;
      end else if (left[k] > 0) begin
        left[k]--;
      end else if (!st) begin
        cur[k] = ref_dec(ins, v, (k == 0), lat);
        left[k] = (lat > 0) ? lat - 1 : 0;
      end
      cur[k].busy = (left[k] > 0);
    end
    q.push_back({cur[0], cur[1]});
  endtask

  task automatic reset_now();
    @(negedge clk);
    chk("busy_pre_rst", {63'd0, Busy_m}, {63'd0, cur[0].busy});
    rst = 1'b1;
    #1;
    chk("rst_async_m", {34'd0, act_m}, 64'd0);
    chk("rst_async_i", {34'd0, act_i}, 64'd0);
    for (int k = 0; k < 2; k++) begin cur[k] = '0; left[k] = 0; end
    q.push_back(60'd0);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    int p;
    r = $urandom;
    p = $urandom_range(0, 12);
    if (p < 12) r[6:0] = OPS[p];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  // monitor: one expected entry per clock edge
  always @(posedge clk) begin
    logic [59:0] e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_m", {34'd0, act_m}, {34'd0, e[59:30]});
      chk("ex_i", {34'd0, act_i}, {34'd0, e[29:0]});
    end
  end

  localparam logic [31:0] ADDI = 32'h00500093, SW = 32'h0020A023, JAL = 32'h0000006F;
  localparam logic [31:0] MUL = 32'h022081B3, DIV = 32'h0220C1B3;

  initial begin
    rst = 1'b1; InstrD = 32'd0; ValidD = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    for (int k = 0; k < 2; k++) begin cur[k] = '0; left[k] = 0; end
    #3;
    chk("reset_m", {34'd0, act_m}, 64'd0);
    chk("reset_i", {34'd0, act_i}, 64'd0);

    step(ADDI, 1, 0, 0);
    step(SW, 1, 0, 0);
    step(JAL, 1, 0, 0);
    step(32'hFFFFFFFF, 1, 0, 0);
    step(32'h02005093, 1, 0, 0);  // SRAI with funct7=0000001
    step(32'h40105093, 1, 0, 0);  // SRAI
    step(MUL, 1, 0, 0);
    step(ADDI, 1, 0, 0);
    step(SW, 1, 0, 0);
    step(32'h123450B7, 1, 0, 0);  // lui
    step(32'h00001097, 1, 0, 0);  // auipc
    step(32'h000080E7, 1, 0, 0);  // jalr
    step(32'h000090E7, 1, 0, 0);  // jalr funct3=001
    step(32'h00208463, 1, 0, 0);  // beq
    step(32'h0020D463, 1, 0, 0);  // bge
    step(32'h0020E463, 1, 0, 0);  // bltu
    step(32'h0020A463, 1, 0, 0);  // branch funct3=010
    step(32'h00008083, 1, 0, 0);  // lb
    step(32'h0000D083, 1, 0, 0);  // lhu
    step(32'h0000B083, 1, 0, 0);  // load funct3=011
    step(32'h00209023, 1, 0, 0);  // sh
    step(32'h0000000F, 1, 0, 0);  // fence
    step(32'h00000073, 1, 0, 0);  // ecall
    step(32'h402081B3, 1, 0, 0);  // sub
    step(32'h402091B3, 1, 0, 0);  // funct7=0100000 with sll
    step(32'h0020B1B3, 1, 0, 0);  // sltu
    step(ADDI, 0, 0, 0);          // bubble
    step(ADDI, 1, 0, 0);
    step(SW, 1, 1, 0);            // stall holds
    step(SW, 1, 0, 1);            // flush idle
    // full divide, next instruction lands 33 edges later
    step(DIV, 1, 0, 0);
    repeat (34) step(ADDI, 1, 0, 0);
    // divide cancelled by flush on busy cycle 10
    step(DIV, 1, 0, 0);
    repeat (9) step(SW, 1, 0, 0);
    step(SW, 1, 0, 1);
    step(ADDI, 1, 0, 0);
    // back-to-back multiplies
    step(MUL, 1, 0, 0);
    step(32'h0220B1B3, 1, 0, 0);  // mulhu
    step(32'h0220A1B3, 1, 0, 0);  // mulhsu
    step(ADDI, 1, 0, 0);
    step(ADDI, 1, 0, 0);
    // stall noise during a divide has no effect on its occupancy
    step(32'h0220F1B3, 1, 0, 0);  // remu
    repeat (34) step(SW, 1, 1'($urandom_range(0, 1)), 0);
    step(SW, 1, 0, 0);
    // asynchronous reset while busy
    step(DIV, 1, 0, 0);
    repeat (5) step(ADDI, 1, 0, 0);
    reset_now();
    step(ADDI, 1, 0, 0);
    step(JAL, 1, 0, 0);

    repeat (1500) step(rnd_instr(), ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 6) == 0), ($urandom_range(0, 39) == 0));
    step(32'd0, 0, 0, 0);

    @(posedge clk);
    #3;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ctrl_decode_rv32m.md
# ctrl_decode_rv32m

Registered RV32I/RV32M instruction decoder with an integrated ID/EX control register and a multi-cycle MUL/DIV occupancy sequencer. It sits between the ID and EX stages of the pipelined core. It decodes the 32-bit instruction in ID into the core's standard control encodings plus optional M-extension ALU codes and an illegal-instruction flag, then registers them into EX. While a multi-cycle multiply/divide occupies EX, it holds that register and raises a stall request to the hazard unit.

## Interface
- `M_EXT`, 1: 1 decodes RV32M; 0 treats funct7=0000001 R-type ops as illegal.
- `MUL_LATENCY`, 2: EX occupancy in cycles for MUL/MULH/MULHSU/MULHU. Legal range 1..63.
- `DIV_LATENCY`, 33: EX occupancy in cycles for DIV/DIVU/REM/REMU. Legal range 1..63.
- `ALU_W`, 5: AluContrlE width. Must be ≥5 when M_EXT=1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `InstrD` in 32: instruction in ID.
- `ValidD` in 1: InstrD holds a real instruction. When low, InstrD is decoded as a bubble.
- `StallE` in 1: external hold of the EX register (hazard unit).
- `FlushE` in 1: clear the EX register to a bubble.
- `JalD`, `JalrD` out 1 each: combinational, equal to ValidD & opcode match, for early redirect.
- `ValidE` out 1: EX holds a real instruction.
- `IllegalE` out 1: EX holds an undecodable instruction.
- `RegWriteE` out 3: 0 none, 1 LB, 2 LH, 3 LW/ALU result, 4 LBU, 5 LHU.
- `MemToRegE` out 1; `MemWriteE` out 4 (0001 SB, 0011 SH, 1111 SW); `LoadNpcE` out 1; `RegReadE` out 2 ([1] rs1 used, [0] rs2 used).
- `BranchTypeE` out 3: 0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BLTU, 5 BGE, 6 BGEU.
- `AluContrlE` out ALU_W: 0 SLL, 1 SRL, 2 SRA, 3 ADD, 4 SUB, 5 XOR, 6 OR, 7 AND, 8 SLT, 9 SLTU, 10 LUI, 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
- `AluSrc1E` out 1 (1 = PC, for AUIPC); `AluSrc2E` out 2 (00 reg, 01 shamt, 10 imm).
- `ImmTypeE` out 3: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J.
- `JalE`, `JalrE` out 1 each.
- `MulDivBusy` out 1: EX register is held by an in-flight multi-cycle op. The hazard unit ORs this into the stall of IF/ID.

## Operation
- Decode is combinational from InstrD[6:0], [14:12] and [31:25]. It covers LUI, AUIPC, JAL, JALR (funct3 000), branches, loads, stores, OP-IMM, OP, and RV32M when M_EXT=1.
- Shift-immediates require funct7 = 0000000 (SLLI/SRLI) or 0100000 (SRAI).
- OP requires funct7 = 0000000, or 0100000 for SUB/SRA only.
- FENCE (0001111) decodes as a legal NOP: all write, branch and jump controls are 0.
- Every other encoding, including SYSTEM, sets IllegalE=1 and forces RegWrite, MemWrite, MemToReg, Branch, Jal, Jalr and LoadNpc to 0.
- No output ever carries X. Unused fields take these values: AluContrl = 3 (ADD), ImmType = 0, AluSrc = 0, RegRead = 00.
- AluContrl = ADD for loads, stores, ADD, ADDI, AUIPC, JAL and JALR. Branches also use ADD, with AluSrc2 = 00.
- A bubble (ValidD=0, or a flushed slot) has all E outputs equal to their reset values.
- Occupancy counter `cnt` is 6 bits wide.
  - On capture of a valid M-op, cnt loads LAT−1, where LAT is MUL_LATENCY or DIV_LATENCY.
  - While cnt≠0: MulDivBusy=1, the EX register holds, and cnt decrements every cycle regardless of StallE.
- Update priority at each clock edge: rst > FlushE > MulDivBusy hold > StallE hold > capture of the decoded InstrD.
- FlushE during busy clears the EX register and sets cnt=0 (cancels the op). MulDivBusy falls in the next cycle.

## Timing
- Reset (asynchronous): all E outputs 0, cnt=0, MulDivBusy=0. With rst low, decoding resumes on the first clock edge.
- Decode-to-EX latency is 1 cycle: InstrD presented before edge k appears on the E outputs after edge k.
- An M-op captured at edge k occupies EX from edge k through edge k+LAT (exclusive). MulDivBusy is high for the LAT−1 cycles after edge k.
  - LAT=1: no busy cycle.
  - The next instruction is captured at edge k+LAT, provided it is not stalled.
- Back-to-back M-ops: the second is captured in the same edge that releases the first, and cnt reloads.
- StallE=1 with cnt=0: the E outputs hold their values and cnt stays 0.

## Test plan
- Reset mid-busy: assert rst while MulDivBusy=1 → all outputs 0 immediately, without waiting for a clock edge.
- 0x00500093 (addi x1,x0,5) with ValidD=1 → after 1 edge: RegWriteE=3, AluContrlE=3, AluSrc2E=10, ImmTypeE=1, RegReadE=10, IllegalE=0.
- 0x0020A023 (sw x2,0(x1)) → MemWriteE=1111, RegWriteE=0, ImmTypeE=2, RegReadE=11.
- 0x0220C1B3 (div x3,x1,x2) with DIV_LATENCY=33 → AluContrlE=15 and MulDivBusy=1 for exactly 32 cycles; the next instruction is captured at edge 33. Assert FlushE at busy cycle 10 → MulDivBusy=0 and ValidE=0 after that edge.
- 0x022081B3 (mul) with M_EXT=0 → IllegalE=1, RegWriteE=0. With M_EXT=1 and MUL_LATENCY=2 → AluContrlE=11 and exactly 1 busy cycle.
- Boundary encodings: 0xFFFFFFFF → IllegalE=1. SRAI with funct7=0000001 → IllegalE=1. 0x0000006F (jal) → JalD=1 combinationally, then LoadNpcE=1, ImmTypeE=5.
